xadac_axi_bridge: RTL and testbench
===================================

Name: xadac_axi_bridge

Overview:
- Parametrised AXI4 master port for the xadac vector units; replaces the single-beat, fixed-width AXI tie-off of the xadac top level.
- Converts one vector-wide read or write request into an INCR burst of AXI beats when VecDataWidth > AxiDataWidth.
- Reassembles read beats and tracks B responses, so units get one completion per request.
- Bounds outstanding reads and writes independently.

Parameters:
- VecDataWidth, 256: vector request data width in bits.
- AxiDataWidth, 64: AXI data width. VecDataWidth/AxiDataWidth must be a power of two ≥1; this quotient is Ratio.
- AddrWidth, 64: address width.
- IdWidth, 4: unit request ID width, also the AXI ID width.
- AxiId, 0: constant AXI ID used on every AR and AW, so responses return in order.
- MaxOutstanding, 4: depth of each ID FIFO, read and write separately.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rd_req_valid/rd_req_ready  in/out  1  read request handshake.
- rd_req_id  in  IdWidth  read request ID.
- rd_req_addr  in  AddrWidth  read request address.
- rd_rsp_valid/rd_rsp_ready  out/in  1  read completion handshake.
- rd_rsp_id  out  IdWidth  ID of the completed read.
- rd_rsp_data  out  VecDataWidth  assembled read data.
- rd_rsp_err  out  1  read error flag.
- wr_req_valid/wr_req_ready  in/out  1  write request handshake.
- wr_req_id  in  IdWidth  write request ID.
- wr_req_addr  in  AddrWidth  write request address.
- wr_req_data  in  VecDataWidth  write data.
- wr_req_strb  in  VecDataWidth/8  write byte strobes.
- wr_rsp_valid/wr_rsp_ready  out/in  1  write completion handshake.
- wr_rsp_id  out  IdWidth  ID of the completed write.
- wr_rsp_err  out  1  write error flag.
- AR channel: ar_id, ar_addr, ar_len[7:0], ar_size[2:0], ar_burst[1:0], ar_valid (out); ar_ready (in).
- R channel: r_id, r_data[AxiDataWidth], r_resp[1:0], r_last, r_valid (in); r_ready (out).
- AW channel: aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid (out); aw_ready (in).
- W channel: w_data, w_strb, w_last, w_valid (out); w_ready (in).
- B channel: b_id, b_resp, b_valid (in); b_ready (out).

Behaviour:
- Reset: every valid and ready output is 0; beat counters are 0; both ID FIFOs are empty; rd_rsp_data and both err outputs are 0. A sync reset mid-burst abandons the burst; no completion is ever issued for abandoned requests.
- Constant AXI fields:
  - ar_len = aw_len = Ratio-1.
  - ar_burst = aw_burst = 2'b01 (INCR).
  - size = clog2(AxiDataWidth/8).
  - ids = AxiId.
  - The address is the request address with its low clog2(VecDataWidth/8) bits forced to 0.
- Read issue:
  - rd_req_ready = 1 when rd FIFO count < MaxOutstanding and the AR register is empty or ar_ready is high.
  - On rd_req handshake: push rd_req_id into the rd FIFO. ar_valid rises the next cycle and is held until ar_ready.
  - No FIFO bypass. A push and a pop in the same cycle on a full FIFO still keep ready low for that cycle.
- Read assembly:
  - r_ready = rd FIFO not empty and rd_rsp_valid is low.
  - Beat k (k = 0..Ratio-1) writes rd_rsp_data[k*AxiDataWidth +: AxiDataWidth].
  - err accumulates the OR of r_resp[1] across beats. err is also set if r_last disagrees with (k == Ratio-1).
  - The cycle after beat Ratio-1: rd_rsp_valid = 1, rd_rsp_id = rd FIFO head. Data, id and err are held stable until rd_rsp_ready.
  - On the rd_rsp handshake: pop the FIFO, clear err and k.
  - Completion latency is 1 cycle after the last R handshake.
- Write issue:
  - Write path states: IDLE, BUSY.
  - wr_req_ready = (state == IDLE) and wr FIFO count < MaxOutstanding.
  - On handshake: latch data and strb, push id into the wr FIFO, go to BUSY. The next cycle aw_valid = 1 and w_valid = 1.
  - The AW and W channels run independently. aw_valid drops after aw_ready. W beat j carries the data and strb slice j; w_last = (j == Ratio-1).
  - BUSY returns to IDLE the cycle after both the AW handshake and the last W handshake have occurred, in either order.
- Write completion:
  - b_ready = wr FIFO not empty and (wr_rsp_valid low or wr_rsp_ready high).
  - The cycle after a B handshake: wr_rsp_valid = 1, wr_rsp_id = wr FIFO head, wr_rsp_err = b_resp[1].
  - The FIFO pops on the wr_rsp handshake.
  - A B response arriving while the wr FIFO is empty is never accepted.
- Independence: the read and write paths share nothing. Simultaneous activity on all five channels is legal.
- Ratio = 1: single-beat bursts, len = 0, w_last is constant 1.

Test Plan:
- Reset held for 3 cycles with traffic on all inputs -> all valid/ready outputs 0. After release, rd_req_ready = 1 and wr_req_ready = 1.
- Read id=5, addr=0x1010 (Vec 256/Axi 64):
  - Required: ar_addr = 0x1000, len = 3, size = 3, burst = 1.
  - R beats 0x11, 0x22, 0x33, 0x44 with r_last on the 4th.
  - Result: rd_rsp_data = {0x44,0x33,0x22,0x11} slices, id = 5, err = 0, one cycle after beat 4.
- Read whose beat 2 has r_resp = 2'b10 -> rd_rsp_err = 1. The following read with clean beats returns err = 0.
- Write id=3, strb = all-ones except byte 0, with aw_ready delayed 5 cycles and w_ready toggling:
  - 4 W beats with the correct slices; w_strb on beat 0 = 0xFE; w_last only on beat 4.
  - wr_req_ready returns to 1 only after both channels complete.
  - A B handshake with b_resp = 0 gives wr_rsp id = 3, err = 0.
- Issue 5 reads with MaxOutstanding = 4 and rd_rsp_ready held 0:
  - The 5th read is stalled (rd_req_ready = 0) and r_ready goes low after the first completion.
  - Releasing rd_rsp_ready drains IDs in issue order.
- Reset asserted during R beat 2 -> rd_rsp_valid is never raised for that request. A fresh read after reset completes normally.

Source files
------------

// File: rtl/xadac_axi_bridge.sv
// AXI4 master bridge for the xadac vector units: splits vector-wide requests
// into INCR bursts, reassembles read data and returns one completion per request.

module xadac_id_fifo #(
  parameter int Depth = 4,
  parameter int Width = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [Width-1:0]             push_data,
  input  logic                         pop,
  output logic [Width-1:0]             head,
  output logic [$clog2(Depth+1)-1:0]   count
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

module xadac_axi_bridge #(
  parameter int VecDataWidth   = 256,
  parameter int AxiDataWidth   = 64,
  parameter int AddrWidth      = 64,
  parameter int IdWidth        = 4,
  parameter int AxiId          = 0,
  parameter int MaxOutstanding = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_req_valid,
  output logic                        rd_req_ready,
  input  logic [IdWidth-1:0]          rd_req_id,
  input  logic [AddrWidth-1:0]        rd_req_addr,
  output logic                        rd_rsp_valid,
  input  logic                        rd_rsp_ready,
  output logic [IdWidth-1:0]          rd_rsp_id,
  output logic [VecDataWidth-1:0]     rd_rsp_data,
  output logic                        rd_rsp_err,
  input  logic                        wr_req_valid,
  output logic                        wr_req_ready,
  input  logic [IdWidth-1:0]          wr_req_id,
  input  logic [AddrWidth-1:0]        wr_req_addr,
  input  logic [VecDataWidth-1:0]     wr_req_data,
  input  logic [VecDataWidth/8-1:0]   wr_req_strb,
  output logic                        wr_rsp_valid,
  input  logic                        wr_rsp_ready,
  output logic [IdWidth-1:0]          wr_rsp_id,
  output logic                        wr_rsp_err,
  output logic [IdWidth-1:0]          ar_id,
  output logic [AddrWidth-1:0]        ar_addr,
  output logic [7:0]                  ar_len,
  output logic [2:0]                  ar_size,
  output logic [1:0]                  ar_burst,
  output logic                        ar_valid,
  input  logic                        ar_ready,
  input  logic [IdWidth-1:0]          r_id,
  input  logic [AxiDataWidth-1:0]     r_data,
  input  logic [1:0]                  r_resp,
  input  logic                        r_last,
  input  logic                        r_valid,
  output logic                        r_ready,
  output logic [IdWidth-1:0]          aw_id,
  output logic [AddrWidth-1:0]        aw_addr,
  output logic [7:0]                  aw_len,
  output logic [2:0]                  aw_size,
  output logic [1:0]                  aw_burst,
  output logic                        aw_valid,
  input  logic                        aw_ready,
  output logic [AxiDataWidth-1:0]     w_data,
  output logic [AxiDataWidth/8-1:0]   w_strb,
  output logic                        w_last,
  output logic                        w_valid,
  input  logic                        w_ready,
  input  logic [IdWidth-1:0]          b_id,
  input  logic [1:0]                  b_resp,
  input  logic                        b_valid,
  output logic                        b_ready
);
  localparam int Ratio    = VecDataWidth / AxiDataWidth;
  localparam int BeatW    = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int AxiStrbW = AxiDataWidth / 8;
  localparam int VecLog   = $clog2(VecDataWidth / 8);
  localparam int CntW     = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0]      CntMax   = CntW'(MaxOutstanding);
  localparam logic [BeatW-1:0]     LastBeat = BeatW'(Ratio - 1);
  localparam logic [AddrWidth-1:0] AddrMask =
    ~((AddrWidth'(1) << VecLog) - AddrWidth'(1));

  typedef enum logic {IDLE, BUSY} wr_state_t;

  logic [CntW-1:0]         rd_count;
  logic [CntW-1:0]         wr_count;
  logic [IdWidth-1:0]      wr_head;
  logic                    rd_push, rd_pop, r_hs;
  logic                    wr_push, wr_pop, aw_hs, w_hs, b_hs;
  logic [BeatW-1:0]        rd_beat;
  logic [BeatW-1:0]        wr_beat;
  logic [VecDataWidth-1:0] wr_data_q;
  logic [VecDataWidth/8-1:0] wr_strb_q;
  wr_state_t               state, state_next;
  logic                    unused_bits;

  assign unused_bits = ^{r_id, b_id, r_resp[0], b_resp[0]};

  assign ar_id    = IdWidth'(AxiId);
  assign aw_id    = IdWidth'(AxiId);
  assign ar_len   = 8'(Ratio - 1);
  assign aw_len   = 8'(Ratio - 1);
  assign ar_size  = 3'($clog2(AxiStrbW));
  assign aw_size  = 3'($clog2(AxiStrbW));
  assign ar_burst = 2'b01;
  assign aw_burst = 2'b01;

  // Readies are gated by reset so nothing is accepted while it is held.
  assign rd_req_ready = !rst && (rd_count < CntMax) && (!ar_valid || ar_ready);
  assign rd_push      = rd_req_valid && rd_req_ready;
  assign rd_pop       = rd_rsp_valid && rd_rsp_ready;
  assign r_ready      = (rd_count != '0) && !rd_rsp_valid;
  assign r_hs         = r_valid && r_ready;

  xadac_id_fifo #(.Depth(MaxOutstanding), .Width(IdWidth)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_push),
    .push_data (rd_req_id),
    .pop       (rd_pop),
    .head      (rd_rsp_id),
    .count     (rd_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_valid <= 1'b0;
      ar_addr  <= '0;
    end else if (rd_push) begin
      ar_valid <= 1'b1;
      ar_addr  <= rd_req_addr & AddrMask;
    end else if (ar_ready) begin
      ar_valid <= 1'b0;
    end
  end

  // A misplaced r_last in either direction is reported as an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_beat      <= '0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
      rd_rsp_err   <= 1'b0;
    end else if (r_hs) begin
      for (int k = 0; k < Ratio; k++) begin
        if (rd_beat == BeatW'(k)) rd_rsp_data[k*AxiDataWidth +: AxiDataWidth] <= r_data;
      end
      rd_rsp_err <= rd_rsp_err | r_resp[1] | (r_last != (rd_beat == LastBeat));
      if (rd_beat == LastBeat) begin
        rd_beat      <= '0;
        rd_rsp_valid <= 1'b1;
      end else begin
        rd_beat <= rd_beat + BeatW'(1);
      end
    end else if (rd_pop) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_err   <= 1'b0;
      rd_beat      <= '0;
    end
  end

  assign wr_req_ready = !rst && (state == IDLE) && (wr_count < CntMax);
  assign wr_push      = wr_req_valid && wr_req_ready;
  assign aw_hs        = aw_valid && aw_ready;
  assign w_hs         = w_valid && w_ready;
  assign w_last       = (wr_beat == LastBeat);
  assign wr_pop       = wr_rsp_valid && wr_rsp_ready;
  assign b_ready      = (wr_count != '0) && (!wr_rsp_valid || wr_rsp_ready);
  assign b_hs         = b_valid && b_ready;

  xadac_id_fifo #(.Depth(MaxOutstanding), .Width(IdWidth)) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_push),
    .push_data (wr_req_id),
    .pop       (wr_pop),
    .head      (wr_head),
    .count     (wr_count)
  );

  assign wr_rsp_id = wr_head;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A channel whose valid is already low in BUSY has finished its part.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (wr_push) state_next = BUSY;
      BUSY: if ((!aw_valid || aw_hs) && (!w_valid || (w_hs && w_last))) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_valid  <= 1'b0;
      aw_addr   <= '0;
      w_valid   <= 1'b0;
      wr_beat   <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else if (wr_push) begin
      aw_valid  <= 1'b1;
      aw_addr   <= wr_req_addr & AddrMask;
      w_valid   <= 1'b1;
      wr_beat   <= '0;
      wr_data_q <= wr_req_data;
      wr_strb_q <= wr_req_strb;
    end else begin
      if (aw_hs) aw_valid <= 1'b0;
      if (w_hs) begin
        if (w_last) begin
          w_valid <= 1'b0;
          wr_beat <= '0;
        end else begin
          wr_beat <= wr_beat + BeatW'(1);
        end
      end
    end
  end

  always_comb begin
    w_data = '0;
    w_strb = '0;
    for (int k = 0; k < Ratio; k++) begin
      if (wr_beat == BeatW'(k)) begin
        w_data = wr_data_q[k*AxiDataWidth +: AxiDataWidth];
        w_strb = wr_strb_q[k*AxiStrbW +: AxiStrbW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_rsp_valid <= 1'b0;
      wr_rsp_err   <= 1'b0;
    end else if (b_hs) begin
      wr_rsp_valid <= 1'b1;
      wr_rsp_err   <= b_resp[1];
    end else if (wr_pop) begin
      wr_rsp_valid <= 1'b0;
      wr_rsp_err   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_xadac_axi_bridge.sv
// Directed bench for xadac_axi_bridge at 256-bit vectors over a 64-bit AXI port.

module tb_xadac_axi_bridge;
  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req_valid, rd_req_ready;
  logic [3:0]    rd_req_id;
  logic [63:0]   rd_req_addr;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [3:0]    rd_rsp_id;
  logic [255:0]  rd_rsp_data;
  logic          rd_rsp_err;
  logic          wr_req_valid, wr_req_ready;
  logic [3:0]    wr_req_id;
  logic [63:0]   wr_req_addr;
  logic [255:0]  wr_req_data;
  logic [31:0]   wr_req_strb;
  logic          wr_rsp_valid, wr_rsp_ready;
  logic [3:0]    wr_rsp_id;
  logic          wr_rsp_err;
  logic [3:0]    ar_id;
  logic [63:0]   ar_addr;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;
  logic          ar_valid, ar_ready;
  logic [3:0]    r_id;
  logic [63:0]   r_data;
  logic [1:0]    r_resp;
  logic          r_last, r_valid, r_ready;
  logic [3:0]    aw_id;
  logic [63:0]   aw_addr;
  logic [7:0]    aw_len;
  logic [2:0]    aw_size;
  logic [1:0]    aw_burst;
  logic          aw_valid, aw_ready;
  logic [63:0]   w_data;
  logic [7:0]    w_strb;
  logic          w_last, w_valid, w_ready;
  logic [3:0]    b_id;
  logic [1:0]    b_resp;
  logic          b_valid, b_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  xadac_axi_bridge dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_id(rd_req_id), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_id(rd_rsp_id), .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_id(wr_req_id), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_strb(wr_req_strb),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready),
    .wr_rsp_id(wr_rsp_id), .wr_rsp_err(wr_rsp_err),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Beat k of a burst carries seed*(k+1).
  function automatic logic [255:0] expVec(input logic [7:0] seed);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*64 +: 64] = 64'(seed) * 64'(k + 1);
    return v;
  endfunction

  task automatic rdReq(input logic [3:0] id, input logic [63:0] addr);
    rd_req_valid = 1'b1;
    rd_req_id    = id;
    rd_req_addr  = addr;
    for (int i = 0; i < 50 && !rd_req_ready; i++) applyStimulus(1);
    checkOutput("rd_req_ready wait", rd_req_ready, 1);
    applyStimulus(1);
    rd_req_valid = 1'b0;
  endtask

  task automatic rBurst(input logic [7:0] seed, input int errBeat, input int lastBeat);
    for (int k = 0; k < 4; k++) begin
      r_valid = 1'b1;
      r_data  = 64'(seed) * 64'(k + 1);
      r_resp  = (k == errBeat) ? 2'b10 : 2'b00;
      r_last  = (k == lastBeat);
      for (int i = 0; i < 50 && !r_ready; i++) applyStimulus(1);
      checkOutput("r_ready wait", r_ready, 1);
      applyStimulus(1);
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_resp  = 2'b00;
  endtask

  task automatic popRd();
    rd_rsp_ready = 1'b1;
    applyStimulus(1);
    rd_rsp_ready = 1'b0;
  endtask

  task automatic bBeat(input logic [1:0] resp);
    b_valid = 1'b1;
    b_resp  = resp;
    for (int i = 0; i < 50 && !b_ready; i++) applyStimulus(1);
    checkOutput("b_ready wait", b_ready, 1);
    applyStimulus(1);
    b_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] expW [4];
    logic [7:0]  expS [4];
    int          beats;
    bit          awSeen;
    bit          seen;

    expW[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    expW[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    expW[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    expW[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    expS[0] = 8'hFE; expS[1] = 8'hFF; expS[2] = 8'hFF; expS[3] = 8'hFF;

    // Reset with every input toggled active.
    rst = 1'b1;
    rd_req_valid = 1'b1; rd_req_id = 4'hF; rd_req_addr = '1;
    wr_req_valid = 1'b1; wr_req_id = 4'hF; wr_req_addr = '1;
    wr_req_data = '1; wr_req_strb = '1;
    rd_rsp_ready = 1'b1; wr_rsp_ready = 1'b1;
    ar_ready = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
    r_valid = 1'b1; r_id = 4'h0; r_data = '1; r_resp = 2'b10; r_last = 1'b1;
    b_valid = 1'b1; b_id = 4'h0; b_resp = 2'b10;
    applyStimulus(3);
    checkOutput("rst ar_valid", ar_valid, 0);
    checkOutput("rst aw_valid", aw_valid, 0);
    checkOutput("rst w_valid", w_valid, 0);
    checkOutput("rst r_ready", r_ready, 0);
    checkOutput("rst b_ready", b_ready, 0);
    checkOutput("rst rd_req_ready", rd_req_ready, 0);
    checkOutput("rst wr_req_ready", wr_req_ready, 0);
    checkOutput("rst rd_rsp_valid", rd_rsp_valid, 0);
    checkOutput("rst wr_rsp_valid", wr_rsp_valid, 0);
    checkOutput("rst rd_rsp_data", rd_rsp_data, 0);
    checkOutput("rst rd_rsp_err", rd_rsp_err, 0);
    checkOutput("rst wr_rsp_err", wr_rsp_err, 0);

    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    rd_rsp_ready = 1'b0; wr_rsp_ready = 1'b0;
    ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
    r_valid = 1'b0; r_resp = 2'b00; r_last = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("post-rst rd_req_ready", rd_req_ready, 1);
    checkOutput("post-rst wr_req_ready", wr_req_ready, 1);

    // Basic read with AR held off for two cycles.
    rdReq(4'd5, 64'h1010);
    checkOutput("ar_valid", ar_valid, 1);
    checkOutput("ar_addr", ar_addr, 64'h1000);
    checkOutput("ar_len", ar_len, 3);
    checkOutput("ar_size", ar_size, 3);
    checkOutput("ar_burst", ar_burst, 1);
    checkOutput("ar_id", ar_id, 0);
    applyStimulus(2);
    checkOutput("ar_valid hold", ar_valid, 1);
    ar_ready = 1'b1;
    applyStimulus(1);
    checkOutput("ar_valid drop", ar_valid, 0);
    rBurst(8'h11, -1, 3);
    checkOutput("rd1 valid", rd_rsp_valid, 1);
    checkOutput("rd1 data", rd_rsp_data,
                {64'h44, 64'h33, 64'h22, 64'h11});
    checkOutput("rd1 id", rd_rsp_id, 5);
    checkOutput("rd1 err", rd_rsp_err, 0);
    applyStimulus(2);
    checkOutput("rd1 valid held", rd_rsp_valid, 1);
    checkOutput("rd1 data held", rd_rsp_data, expVec(8'h11));
    popRd();
    checkOutput("rd1 popped", rd_rsp_valid, 0);

    // Error on the second beat, then a clean read.
    rdReq(4'd7, 64'h2000);
    applyStimulus(1);
    rBurst(8'h05, 1, 3);
    checkOutput("rd2 err", rd_rsp_err, 1);
    checkOutput("rd2 id", rd_rsp_id, 7);
    checkOutput("rd2 data", rd_rsp_data, expVec(8'h05));
    popRd();
    rdReq(4'd2, 64'h2020);
    applyStimulus(1);
    rBurst(8'h09, -1, 3);
    checkOutput("rd3 err", rd_rsp_err, 0);
    checkOutput("rd3 id", rd_rsp_id, 2);
    popRd();

    // r_last on the wrong beat.
    rdReq(4'd8, 64'h2040);
    applyStimulus(1);
    rBurst(8'h0D, -1, 2);
    checkOutput("rd4 last err", rd_rsp_err, 1);
    checkOutput("rd4 id", rd_rsp_id, 8);
    popRd();

    // Write with delayed AW and toggling W ready.
    wr_req_valid = 1'b1;
    wr_req_id    = 4'd3;
    wr_req_addr  = 64'h3008;
    wr_req_data  = {expW[3], expW[2], expW[1], expW[0]};
    wr_req_strb  = 32'hFFFF_FFFE;
    checkOutput("wr_req_ready idle", wr_req_ready, 1);
    applyStimulus(1);
    wr_req_valid = 1'b0;
    beats  = 0;
    awSeen = 1'b0;
    for (int c = 0; c < 40 && !(awSeen && beats == 4); c++) begin
      aw_ready = (c >= 5);
      w_ready  = c[0];
      if (c == 2) checkOutput("wr_req_ready busy", wr_req_ready, 0);
      if (w_valid && w_ready && beats < 4) begin
        checkOutput($sformatf("w_data beat%0d", beats), w_data, expW[beats]);
        checkOutput($sformatf("w_strb beat%0d", beats), w_strb, expS[beats]);
        checkOutput($sformatf("w_last beat%0d", beats), w_last, (beats == 3));
        beats++;
      end
      if (aw_valid && aw_ready) begin
        checkOutput("aw_addr", aw_addr, 64'h3000);
        checkOutput("aw_len", aw_len, 3);
        checkOutput("aw_burst", aw_burst, 1);
        awSeen = 1'b1;
      end
      applyStimulus(1);
    end
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    checkOutput("w beat count", beats, 4);
    checkOutput("aw handshake seen", awSeen, 1);
    checkOutput("wr_req_ready after", wr_req_ready, 1);
    checkOutput("w_valid after", w_valid, 0);
    bBeat(2'b00);
    checkOutput("wr1 valid", wr_rsp_valid, 1);
    checkOutput("wr1 id", wr_rsp_id, 3);
    checkOutput("wr1 err", wr_rsp_err, 0);
    wr_rsp_ready = 1'b1;
    applyStimulus(1);
    wr_rsp_ready = 1'b0;
    checkOutput("wr1 popped", wr_rsp_valid, 0);
    checkOutput("b_ready empty", b_ready, 0);

    // Write with an error response and both channels always ready.
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    wr_req_valid = 1'b1;
    wr_req_id    = 4'hC;
    wr_req_addr  = 64'h6000;
    applyStimulus(1);
    wr_req_valid = 1'b0;
    applyStimulus(4);
    checkOutput("wr2 idle again", wr_req_ready, 1);
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    bBeat(2'b10);
    checkOutput("wr2 id", wr_rsp_id, 4'hC);
    checkOutput("wr2 err", wr_rsp_err, 1);
    wr_rsp_ready = 1'b1;
    applyStimulus(1);
    wr_rsp_ready = 1'b0;

    // Outstanding limit: four reads accepted, the fifth stalls.
    for (int i = 1; i <= 4; i++) rdReq(4'(i), 64'h8000 + 64'(i * 32));
    rd_req_valid = 1'b1;
    rd_req_id    = 4'd9;
    checkOutput("5th rd stalled", rd_req_ready, 0);
    applyStimulus(1);
    checkOutput("5th rd still stalled", rd_req_ready, 0);
    rd_req_valid = 1'b0;
    rBurst(8'h21, -1, 3);
    checkOutput("full rsp valid", rd_rsp_valid, 1);
    checkOutput("full r_ready low", r_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) rBurst(8'(8'h20 + i), -1, 3);
      checkOutput($sformatf("drain id%0d", i), rd_rsp_id, 4'(i));
      checkOutput($sformatf("drain data%0d", i), rd_rsp_data, expVec(8'(8'h20 + i)));
      popRd();
    end
    checkOutput("drained r_ready", r_ready, 0);
    checkOutput("drained rd_req_ready", rd_req_ready, 1);

    // Reset during the second R beat abandons the read.
    rdReq(4'd6, 64'h4000);
    applyStimulus(1);
    r_valid = 1'b1; r_data = 64'h99; r_resp = 2'b00; r_last = 1'b0;
    applyStimulus(1);
    r_data = 64'hAA;
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    r_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rd_rsp_valid) seen = 1'b1;
      applyStimulus(1);
    end
    checkOutput("abandoned rsp", seen, 0);
    checkOutput("abandoned r_ready", r_ready, 0);
    checkOutput("abandoned data", rd_rsp_data, 0);
    rdReq(4'hA, 64'h505F);
    checkOutput("fresh ar_addr", ar_addr, 64'h5040);
    applyStimulus(1);
    rBurst(8'h31, -1, 3);
    checkOutput("fresh valid", rd_rsp_valid, 1);
    checkOutput("fresh id", rd_rsp_id, 4'hA);
    checkOutput("fresh data", rd_rsp_data, expVec(8'h31));
    checkOutput("fresh err", rd_rsp_err, 0);
    popRd();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
